ccff_chain_loader: RTL and testbench



---
 rtl/ccff_chain_loader_if.sv | 21 ++
 rtl/ccff_chain_loader.sv | 180 ++++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccff_chain_loader_if.sv
// ccff_chain_loader_if: valid/ready configuration word bus between the
// bitstream distributor (master) and the chain loader (slave).
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams configuration words LSB-first onto one fle ccff chain.
// Optional macro CCFF_READBACK_EN: second pass checks ccff_tail against the stream.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 26,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 8
) (
  input  logic               prog_clk,
  input  logic               prog_reset,
  input  logic               start,
  ccff_chain_loader_if.slave cfg,
  output logic               ccff_head,
  input  logic               ccff_tail,
  output logic               ccff_shift_en,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

`ifdef CCFF_READBACK_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  localparam int WORDS_PER_PASS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int TOTAL_WORDS    = PASSES * WORDS_PER_PASS;
  localparam int TOTAL_SHIFTS   = PASSES * CHAIN_LEN;
  localparam int LAST_BITS      = (CHAIN_LEN % WORD_W == 0) ? WORD_W : (CHAIN_LEN % WORD_W);
  localparam int BIT_W          = CNT_W + PASSES - 1;
  localparam int WCNT_W         = $clog2(TOTAL_WORDS + 1);
  localparam int WIDX_W         = $clog2(WORDS_PER_PASS + 1);
  localparam int SCNT_W         = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WORD_W-1:0] hold_reg;
  logic              hold_full;
  logic              hold_last;
  logic [WORD_W-1:0] shift_reg;
  logic [SCNT_W-1:0] shift_cnt;
  logic [WCNT_W-1:0] word_cnt;
  logic [WIDX_W-1:0] word_idx;
  logic [BIT_W-1:0]  bit_cnt;
  logic              head_q;

  logic word_ready;
  logic accept;
  logic shifting;
  logic reload;
  logic final_shift;
  logic load_go;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Reload also fires while the last valid bit is leaving, so a steady source never stalls the chain.
  always_comb begin
    state_d       = state_q;
    word_ready    = 1'b0;
    accept        = 1'b0;
    shifting      = 1'b0;
    reload        = 1'b0;
    final_shift   = 1'b0;
    load_go       = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = head_q;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          load_go = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        word_ready    = !hold_full && (word_cnt < WCNT_W'(TOTAL_WORDS));
        accept        = cfg.cfg_valid && word_ready;
        shifting      = (shift_cnt != '0);
        reload        = hold_full && ((shift_cnt == '0) || (shift_cnt == SCNT_W'(1)));
        final_shift   = shifting && (bit_cnt == BIT_W'(TOTAL_SHIFTS - 1));
        ccff_shift_en = shifting;
        if (shifting) begin
          ccff_head = shift_reg[0];
        end
        if (final_shift) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cfg.cfg_ready = word_ready;

  always_ff @(posedge prog_clk) begin
    if (prog_reset || load_go) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
      hold_last <= 1'b0;
      shift_reg <= '0;
      shift_cnt <= '0;
      word_cnt  <= '0;
      word_idx  <= '0;
      bit_cnt   <= '0;
    end else begin
      if (accept) begin
        hold_reg  <= cfg.cfg_data;
        hold_full <= 1'b1;
        hold_last <= (word_idx == WIDX_W'(WORDS_PER_PASS - 1));
        word_cnt  <= word_cnt + WCNT_W'(1);
        word_idx  <= (word_idx == WIDX_W'(WORDS_PER_PASS - 1)) ? '0 : word_idx + WIDX_W'(1);
      end
      // The final word of each pass carries only the bits that still fit in the chain.
      if (reload) begin
        shift_reg <= hold_reg;
        shift_cnt <= hold_last ? SCNT_W'(LAST_BITS) : SCNT_W'(WORD_W);
        hold_full <= 1'b0;
      end else if (shifting) begin
        shift_reg <= shift_reg >> 1;
        shift_cnt <= shift_cnt - SCNT_W'(1);
      end
      if (shifting) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      head_q <= 1'b0;
    end else if (shifting) begin
      head_q <= shift_reg[0];
    end
  end

`ifdef CCFF_READBACK_EN
  logic err_q;

  // During pass 2 the tail presents the pass-1 bit with the same index as the head bit.
  always_ff @(posedge prog_clk) begin
    if (prog_reset || load_go) begin
      err_q <= 1'b0;
    end else if (shifting && (bit_cnt >= BIT_W'(CHAIN_LEN)) && (ccff_tail != shift_reg[0])) begin
      err_q <= 1'b1;
    end
  end

  assign cfg_err = err_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign cfg_err     = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: randomized self-checking bench for ccff_chain_loader with
// a behavioural chain model; honours CCFF_READBACK_EN when defined.
`timescale 1ns/1ps
module tb_ccff_chain_loader;

  localparam int CHAIN_LEN = 26;
  localparam int WORD_W    = 8;
  localparam int CNT_W     = 8;
  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int C16       = 16;
`ifdef CCFF_READBACK_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  logic prog_clk = 1'b0;
  logic prog_reset;
  logic start;
  logic ccff_head, ccff_tail, ccff_shift_en, busy, done, cfg_err;

  logic start16;
  logic head16, tail16, shift16, busy16, done16, err16;

  int n_cmp  = 0;
  int n_fail = 0;

  ccff_chain_loader_if #(.WORD_W(WORD_W)) cfg_bus ();
  ccff_chain_loader_if #(.WORD_W(WORD_W)) bus16 ();

  ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .prog_clk     (prog_clk),
    .prog_reset   (prog_reset),
    .start        (start),
    .cfg          (cfg_bus),
    .ccff_head    (ccff_head),
    .ccff_tail    (ccff_tail),
    .ccff_shift_en(ccff_shift_en),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  ccff_chain_loader #(.CHAIN_LEN(C16), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut16 (
    .prog_clk     (prog_clk),
    .prog_reset   (prog_reset),
    .start        (start16),
    .cfg          (bus16),
    .ccff_head    (head16),
    .ccff_tail    (tail16),
    .ccff_shift_en(shift16),
    .busy         (busy16),
    .done         (done16),
    .cfg_err      (err16)
  );

  always #5 prog_clk = ~prog_clk;

  // Behavioural chains; the main one can fake a stuck readback at pass-2 index 7.
  logic [CHAIN_LEN-1:0] chain   = '0;
  logic [C16-1:0]       chain16 = '0;
  int                   tail_idx = -1;
  logic                 stuck7   = 1'b0;

  always @(posedge prog_clk) begin
    if (ccff_shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
    if (shift16)       chain16 <= {chain16[C16-2:0], head16};
  end

  assign ccff_tail = chain[CHAIN_LEN-1] | (stuck7 && (tail_idx == CHAIN_LEN + 7));
  assign tail16    = chain16[C16-1];

  logic [WORD_W-1:0] words [NWORDS];
  bit                exp_bits [$];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void build_stream();
    int nb;
    exp_bits.delete();
    for (int p = 0; p < PASSES; p++) begin
      for (int w = 0; w < NWORDS; w++) begin
        nb = (w < NWORDS - 1) ? WORD_W : CHAIN_LEN - (NWORDS - 1) * WORD_W;
        for (int b = 0; b < nb; b++) exp_bits.push_back(words[w][b]);
      end
    end
  endfunction

  task automatic applyStimulus(input int gap_after, input int gap_len, input int busy_start_at,
                               input int reset_at, input bit stuck);
    int  shifts = 0, accepted = 0, gap_left = 0, cyc = 0;
    int  first = -1, last = -1, done_cnt = 0, done_cyc = -1;
    bit  finished = 0, aborted = 0, start_fired = 0, vld;
    bit  exp_err;
    logic [CHAIN_LEN-1:0] exp_chain;
    build_stream();
    exp_err = stuck && (PASSES == 2) && (exp_bits[7] == 1'b0);
    stuck7 = stuck;
    @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1'b1);
    while (!finished && cyc < 400) begin
      start = 1'b0;
      tail_idx = ccff_shift_en ? shifts : -1;
      if (shifts == CHAIN_LEN + 7 && ccff_shift_en) checkOutput("err_before_idx7", cfg_err, 1'b0);
      if (shifts == CHAIN_LEN + 8 && tail_idx == CHAIN_LEN + 8) checkOutput("err_after_idx7", cfg_err, exp_err);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (ccff_shift_en) begin
        if (shifts < exp_bits.size())
          checkOutput($sformatf("head[%0d]", shifts), ccff_head, exp_bits[shifts]);
        if (first < 0) first = cyc;
        last = cyc;
        shifts++;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        checkOutput("busy_after_done", busy, 1'b0);
        checkOutput("done_single_cycle", done, 1'b0);
        finished = 1;
        cfg_bus.cfg_valid = 1'b0;
      end else if (reset_at >= 0 && shifts == reset_at) begin
        prog_reset = 1'b1;
        cfg_bus.cfg_valid = 1'b0;
        @(negedge prog_clk);
        prog_reset = 1'b0;
        checkOutput("rst_ready", cfg_bus.cfg_ready, 1'b0);
        checkOutput("rst_head", ccff_head, 1'b0);
        checkOutput("rst_shift_en", ccff_shift_en, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_err", cfg_err, 1'b0);
        finished = 1;
        aborted = 1;
      end else begin
        if (busy_start_at >= 0 && shifts == busy_start_at && !start_fired) begin
          start = 1'b1;
          start_fired = 1;
        end
        vld = (gap_left == 0);
        if (gap_left > 0) gap_left--;
        cfg_bus.cfg_valid = vld;
        if (vld) cfg_bus.cfg_data = words[accepted % NWORDS];
        if (vld && cfg_bus.cfg_ready) begin
          if (accepted == gap_after) gap_left = gap_len;
          accepted++;
        end
        @(negedge prog_clk);
        cyc++;
      end
    end
    tail_idx = -1;
    stuck7 = 1'b0;
    start = 1'b0;
    checkOutput("load_terminated", finished, 1'b1);
    if (!aborted) begin
      for (int i = 0; i < CHAIN_LEN; i++) exp_chain[CHAIN_LEN-1-i] = exp_bits[i];
      checkOutput("shift_count", shifts, PASSES * CHAIN_LEN);
      checkOutput("words_accepted", accepted, PASSES * NWORDS);
      checkOutput("done_count", done_cnt, 1);
      checkOutput("done_latency", done_cyc - last, 2);
      if (gap_len == 0 || gap_after < 0) checkOutput("contiguous", last - first + 1, shifts);
      checkOutput("chain_contents", chain, exp_chain);
      checkOutput("cfg_err_final", cfg_err, exp_err);
    end
  endtask

  task automatic run16();
    int   shifts = 0, accepted = 0, done_cnt = 0, cyc = 0;
    bit   fin = 0;
    logic [WORD_W-1:0] acc_words [2];
    logic [63:0] obs = '0, exp = '0;
    @(negedge prog_clk);
    start16 = 1'b1;
    @(negedge prog_clk);
    start16 = 1'b0;
    while (!fin && cyc < 300) begin
      if (shift16) begin
        if (shifts < 64) obs[shifts] = head16;
        shifts++;
      end
      if (done16) begin
        done_cnt++;
        fin = 1;
      end
      bus16.cfg_valid = 1'b1;
      bus16.cfg_data  = (accepted >= 2) ? acc_words[accepted % 2] : WORD_W'($urandom);
      if (bus16.cfg_ready) begin
        if (accepted < 2) acc_words[accepted] = bus16.cfg_data;
        accepted++;
      end
      @(negedge prog_clk);
      cyc++;
    end
    bus16.cfg_valid = 1'b0;
    for (int i = 0; i < PASSES * C16; i++) exp[i] = acc_words[(i % C16) / WORD_W][i % WORD_W];
    checkOutput("s16_terminated", fin, 1'b1);
    checkOutput("s16_words", accepted, PASSES * 2);
    checkOutput("s16_shifts", shifts, PASSES * C16);
    checkOutput("s16_done", done_cnt, 1);
    checkOutput("s16_stream", obs, exp);
    checkOutput("s16_err", err16, 1'b0);
  endtask

  initial begin
    prog_reset = 1'b1;
    start = 1'b0;
    start16 = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_data = '0;
    bus16.cfg_valid = 1'b0;
    bus16.cfg_data = '0;
    repeat (3) @(negedge prog_clk);
    checkOutput("init_ready", cfg_bus.cfg_ready, 1'b0);
    checkOutput("init_head", ccff_head, 1'b0);
    checkOutput("init_shift_en", ccff_shift_en, 1'b0);
    checkOutput("init_busy", busy, 1'b0);
    checkOutput("init_done", done, 1'b0);
    checkOutput("init_err", cfg_err, 1'b0);
    prog_reset = 1'b0;

    words = '{8'hA5, 8'h3C, 8'hFF, 8'h02};
    $display("[TB] fixed stream, continuous valid");
    applyStimulus(-1, 0, -1, -1, 1'b0);
    $display("[TB] fixed stream, 3-cycle valid gap after second word");
    applyStimulus(1, 3, -1, -1, 1'b0);
    $display("[TB] start while busy at shift 10");
    applyStimulus(-1, 0, 10, -1, 1'b0);
    $display("[TB] reset at shift 13 then full reload");
    applyStimulus(-1, 0, -1, 13, 1'b0);
    applyStimulus(-1, 0, -1, -1, 1'b0);

    for (int t = 0; t < 6; t++) begin
      for (int w = 0; w < NWORDS; w++) words[w] = WORD_W'($urandom);
      applyStimulus(int'($urandom_range(0, PASSES * NWORDS - 1)), int'($urandom_range(0, 4)),
                    -1, -1, 1'b0);
    end

`ifdef CCFF_READBACK_EN
    $display("[TB] readback with stuck bit 7");
    for (int w = 0; w < NWORDS; w++) words[w] = WORD_W'($urandom);
    words[0][7] = 1'b0;
    applyStimulus(-1, 0, -1, -1, 1'b1);
    applyStimulus(-1, 0, -1, -1, 1'b0);
`endif

    $display("[TB] CHAIN_LEN=16 instance");
    run16();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
